fmul_arbiter: RTL and testbench



---
 rtl/ed25519_pkg.sv | 16 +
 rtl/rr_arbiter.sv | 42 ++++
 rtl/fmul_arbiter.sv | 132 +++++++++++++
 tb/tb_fmul_arbiter.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ed25519_pkg.sv
// Shared field-arithmetic constants and the multiplier tag type used by the
// field-arithmetic sequencers and the multiplier arbiter.
package ed25519_pkg;

    localparam int WIDTH_FIELD = 256;
    localparam logic [255:0] P = (256'd1 << 255) - 256'd19;

    // Tag id is sized for the largest supported requester count (4)
    localparam int TAG_ID_W = 2;

    typedef struct packed {
        logic                valid;
        logic [TAG_ID_W-1:0] id;
    } mul_tag_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin one-hot grant: first eligible requester scanning upward from ptr,
// wrapping modulo N.
module rr_arbiter #(
    parameter int N     = 2,
    parameter int PTR_W = $clog2(N)
) (
    input  logic [N-1:0]     eligible,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [PTR_W-1:0] grant_id,
    output logic             grant_any
);
    logic [N-1:0] rot_elig;
    logic [N-1:0] rot_grant;

    // Rotate so that bit 0 is the requester at ptr, pick lowest, rotate back
    assign rot_elig = N'({eligible, eligible} >> ptr);

    always_comb begin
        rot_grant = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rot_elig[i]) begin
                rot_grant    = '0;
                rot_grant[i] = 1'b1;
            end
        end
    end

    assign grant = N'(({rot_grant, rot_grant} << ptr) >> N);

    always_comb begin
        grant_id = '0;
        for (int i = 0; i < N; i++) begin
            if (grant[i]) begin
                grant_id = PTR_W'(i);
            end
        end
    end

    assign grant_any = |eligible;

endmodule

// File: rtl/fmul_arbiter.sv
// Shares one fixed-latency field multiplier among N_REQ requesters: round-robin
// issue, tag tracking through the multiplier pipeline, and per-requester return.
module fmul_arbiter
    import ed25519_pkg::*;
#(
    parameter int N_REQ = 2,
    parameter int WIDTH = WIDTH_FIELD,
    parameter int LAT   = 4
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic [N_REQ-1:0]       i_req_valid,
    input  logic [N_REQ*WIDTH-1:0] i_req_a,
    input  logic [N_REQ*WIDTH-1:0] i_req_b,
    output logic [N_REQ-1:0]       o_req_grant,
    output logic [N_REQ-1:0]       o_rsp_valid,
    output logic [WIDTH-1:0]       o_rsp_data,
    output logic                   o_mul_valid,
    output logic [WIDTH-1:0]       o_mul_a,
    output logic [WIDTH-1:0]       o_mul_b,
    input  logic                   i_mul_valid,
    input  logic [WIDTH-1:0]       i_mul_p,
    output logic                   o_err
);
    localparam int ID_W = $clog2(N_REQ);

    logic [N_REQ-1:0] busy_reg;
    logic [N_REQ-1:0] busy_next;
    logic [N_REQ-1:0] eligible;
    logic [N_REQ-1:0] grant;
    logic [N_REQ-1:0] rsp_hit;
    logic [ID_W-1:0]  ptr_reg;
    logic [ID_W-1:0]  ptr_next;
    logic [ID_W-1:0]  grant_id;
    logic [ID_W-1:0]  issue_id_reg;
    logic             grant_any;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;
    mul_tag_t         tag_reg [LAT];
    mul_tag_t         entry_tag;
    mul_tag_t         tail_tag;
    logic             ret_ok;
    logic             err_set;

    // No transfers are accepted while reset is held
    assign eligible = i_req_valid & ~busy_reg & {N_REQ{i_rst_n}};

    rr_arbiter #(
        .N     (N_REQ),
        .PTR_W (ID_W)
    ) u_rr (
        .eligible  (eligible),
        .ptr       (ptr_reg),
        .grant     (grant),
        .grant_id  (grant_id),
        .grant_any (grant_any)
    );

    assign o_req_grant = grant;
    assign ptr_next    = (grant_id == ID_W'(N_REQ - 1)) ? '0 : grant_id + ID_W'(1);

    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (grant[k]) begin
                sel_a = i_req_a[k*WIDTH +: WIDTH];
                sel_b = i_req_b[k*WIDTH +: WIDTH];
            end
        end
    end

    // The tag travels alongside the issue strobe into the multiplier
    always_comb begin
        entry_tag       = '0;
        entry_tag.valid = o_mul_valid;
        entry_tag.id    = TAG_ID_W'(issue_id_reg);
    end

    assign tail_tag = tag_reg[LAT-1];
    assign ret_ok   = i_mul_valid & tail_tag.valid;
    assign err_set  = i_mul_valid ^ tail_tag.valid;

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_req
        assign rsp_hit[gi]   = ret_ok && (tail_tag.id == TAG_ID_W'(gi));
        assign busy_next[gi] = (busy_reg[gi] && !rsp_hit[gi]) || grant[gi];
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            for (int s = 0; s < LAT; s++) begin
                tag_reg[s] <= '0;
            end
        end else begin
            tag_reg[0] <= entry_tag;
            for (int s = 1; s < LAT; s++) begin
                tag_reg[s] <= tag_reg[s-1];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            busy_reg     <= '0;
            ptr_reg      <= '0;
            issue_id_reg <= '0;
            o_mul_valid  <= 1'b0;
            o_mul_a      <= '0;
            o_mul_b      <= '0;
            o_rsp_valid  <= '0;
            o_rsp_data   <= '0;
            o_err        <= 1'b0;
        end else begin
            busy_reg    <= busy_next;
            o_mul_valid <= grant_any;
            if (grant_any) begin
                o_mul_a      <= sel_a;
                o_mul_b      <= sel_b;
                issue_id_reg <= grant_id;
                ptr_reg      <= ptr_next;
            end
            o_rsp_valid <= rsp_hit;
            if (ret_ok) begin
                o_rsp_data <= i_mul_p;
            end
            if (err_set) begin
                o_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fmul_arbiter.sv
// Randomized and directed check of fmul_arbiter against a timeline model of
// grants, issues and returns, using a stub fixed-latency multiplier.
module tb_fmul_arbiter;
    localparam int N    = 2;
    localparam int W    = 256;
    localparam int LAT  = 4;
    localparam int MAXC = 2048;
    localparam int BIG  = 1 << 30;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst_n = 1'b0;
    logic [N-1:0]   req_valid = '0;
    logic [N*W-1:0] req_a = '0;
    logic [N*W-1:0] req_b = '0;
    logic [N-1:0]   grant;
    logic [N-1:0]   rsp_valid;
    logic [W-1:0]   rsp_data;
    logic           mul_valid;
    logic [W-1:0]   mul_a;
    logic [W-1:0]   mul_b;
    logic           mul_in_valid;
    logic [W-1:0]   mul_p;
    logic           err;
    logic           suppress = 1'b0;
    logic           inject = 1'b0;

    fmul_arbiter #(.N_REQ(N), .WIDTH(W), .LAT(LAT)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_req_valid (req_valid),
        .i_req_a     (req_a),
        .i_req_b     (req_b),
        .o_req_grant (grant),
        .o_rsp_valid (rsp_valid),
        .o_rsp_data  (rsp_data),
        .o_mul_valid (mul_valid),
        .o_mul_a     (mul_a),
        .o_mul_b     (mul_b),
        .i_mul_valid (mul_in_valid),
        .i_mul_p     (mul_p),
        .o_err       (err)
    );

    // Stub multiplier sharing the arbiter's reset
    logic         stub_v [LAT];
    logic [W-1:0] stub_p [LAT];
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int s = 0; s < LAT; s++) begin
                stub_v[s] <= 1'b0;
                stub_p[s] <= '0;
            end
        end else begin
            stub_v[0] <= mul_valid;
            stub_p[0] <= mul_a * mul_b;
            for (int s = 1; s < LAT; s++) begin
                stub_v[s] <= stub_v[s-1];
                stub_p[s] <= stub_p[s-1];
            end
        end
    end
    assign mul_in_valid = (stub_v[LAT-1] & ~suppress) | inject;
    assign mul_p        = stub_p[LAT-1];

    // Timeline model: expected outputs indexed by cycle
    logic [N-1:0] e_rsp_valid [MAXC];
    logic [W-1:0] e_rsp_data  [MAXC];
    logic         e_mul_valid [MAXC];
    logic [W-1:0] e_mul_a     [MAXC];
    logic [W-1:0] e_mul_b     [MAXC];
    logic         e_err       [MAXC];
    logic         err_event   [MAXC];
    int           rsp_owner   [MAXC];
    int           busy_until  [N];
    int           m_ptr;

    logic [N-1:0] obs_grant     [MAXC];
    logic [N-1:0] obs_rsp_valid [MAXC];
    logic [W-1:0] obs_rsp_data  [MAXC];
    logic         obs_mul_valid [MAXC];
    logic         obs_err       [MAXC];

    logic [W-1:0] ra [N];
    logic [W-1:0] rb [N];
    int cyc;
    int n_tests;
    int n_fail;
    bit checks_on;

    function automatic logic [W-1:0] rand256();
        logic [W-1:0] r;
        r = '0;
        for (int i = 0; i < W / 32; i++) r = {r[W-33:0], 32'($urandom)};
        return r;
    endfunction

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic step(input logic [N-1:0] v, input logic rn, input logic sup, input logic inj);
        int gk;
        int k;
        int r;
        logic [N-1:0] mg;
        @(negedge clk);
        req_valid = v;
        rst_n     = rn;
        suppress  = sup;
        inject    = inj;
        for (int q = 0; q < N; q++) begin
            req_a[q*W +: W] = ra[q];
            req_b[q*W +: W] = rb[q];
        end
        #1;
        // Grant rule: first eligible from the pointer, wrapping
        gk = -1;
        mg = '0;
        if (rn) begin
            for (int off = 0; off < N; off++) begin
                k = (m_ptr + off) % N;
                if (gk < 0 && v[k] && cyc >= busy_until[k]) gk = k;
            end
        end
        if (gk >= 0) mg[gk] = 1'b1;

        obs_grant[cyc]     = grant;
        obs_rsp_valid[cyc] = rsp_valid;
        obs_rsp_data[cyc]  = rsp_data;
        obs_mul_valid[cyc] = mul_valid;
        obs_err[cyc]       = err;

        if (checks_on) begin
            chk("grant", W'(grant), W'(mg));
            chk("mul_valid", W'(mul_valid), W'(e_mul_valid[cyc]));
            chk("mul_a", mul_a, e_mul_a[cyc]);
            chk("mul_b", mul_b, e_mul_b[cyc]);
            chk("rsp_valid", W'(rsp_valid), W'(e_rsp_valid[cyc]));
            if (e_rsp_valid[cyc] != '0) chk("rsp_data", rsp_data, e_rsp_data[cyc]);
            chk("err", W'(err), W'(e_err[cyc]));
        end
        if (rsp_valid != '0)
            $display("[TB] cycle %0d rsp %b data %0h", cyc, rsp_valid, rsp_data[63:0]);

        if (!rn) begin
            for (int c = cyc + 1; c < MAXC; c++) begin
                rsp_owner[c]   = -1;
                e_rsp_valid[c] = '0;
                err_event[c]   = 1'b0;
            end
            e_rsp_data[cyc+1]  = '0;
            e_mul_valid[cyc+1] = 1'b0;
            e_mul_a[cyc+1]     = '0;
            e_mul_b[cyc+1]     = '0;
            e_err[cyc+1]       = 1'b0;
            for (int q = 0; q < N; q++) busy_until[q] = 0;
            m_ptr     = 0;
            checks_on = 1'b1;
        end else begin
            if (sup && rsp_owner[cyc+1] >= 0) begin
                busy_until[rsp_owner[cyc+1]] = BIG;
                e_rsp_valid[cyc+1] = '0;
                rsp_owner[cyc+1]   = -1;
                err_event[cyc+1]   = 1'b1;
            end
            if (inj && rsp_owner[cyc+1] < 0) err_event[cyc+1] = 1'b1;
            e_mul_valid[cyc+1] = (gk >= 0);
            e_mul_a[cyc+1]     = (gk >= 0) ? ra[gk] : e_mul_a[cyc];
            e_mul_b[cyc+1]     = (gk >= 0) ? rb[gk] : e_mul_b[cyc];
            if (gk >= 0) begin
                r = cyc + 2 + LAT;
                e_rsp_valid[r]     = '0;
                e_rsp_valid[r][gk] = 1'b1;
                e_rsp_data[r]      = ra[gk] * rb[gk];
                rsp_owner[r]       = gk;
                busy_until[gk]     = r;
                m_ptr              = (gk + 1) % N;
                $display("[TB] cycle %0d grant req%0d", cyc, gk);
            end
            if (rsp_owner[cyc+1] < 0) e_rsp_data[cyc+1] = e_rsp_data[cyc];
            e_err[cyc+1] = e_err[cyc] | err_event[cyc+1];
        end
        if (gk >= 0) begin
            ra[gk] = rand256();
            rb[gk] = rand256();
        end
        cyc++;
    endtask

    initial begin
        int c0, c1, ci, c2, c3, c5;
        logic rn;
        n_tests = 0;
        n_fail = 0;
        cyc = 0;
        checks_on = 1'b0;
        m_ptr = 0;
        for (int c = 0; c < MAXC; c++) begin
            rsp_owner[c] = -1;
            e_rsp_valid[c] = '0;
            e_rsp_data[c] = '0;
            e_mul_valid[c] = 1'b0;
            e_mul_a[c] = '0;
            e_mul_b[c] = '0;
            e_err[c] = 1'b0;
            err_event[c] = 1'b0;
        end
        for (int q = 0; q < N; q++) begin
            busy_until[q] = 0;
            ra[q] = '0;
            rb[q] = '0;
        end

        repeat (3) step('0, 1'b0, 1'b0, 1'b0);

        // Single operation 3*5 from requester 0
        ra[0] = 256'd3;
        rb[0] = 256'd5;
        c0 = cyc;
        step(2'b01, 1'b1, 1'b0, 1'b0);
        repeat (9) step('0, 1'b1, 1'b0, 1'b0);

        // Both requesters continuously valid from ptr=0
        step('0, 1'b0, 1'b0, 1'b0);
        c1 = cyc;
        repeat (12) step(2'b11, 1'b1, 1'b0, 1'b0);
        repeat (8) step('0, 1'b1, 1'b0, 1'b0);

        // Spurious result with nothing in flight
        ci = cyc;
        step('0, 1'b1, 1'b0, 1'b1);
        repeat (4) step('0, 1'b1, 1'b0, 1'b0);

        // Missing result for requester 0
        step('0, 1'b0, 1'b0, 1'b0);
        c2 = cyc;
        step(2'b01, 1'b1, 1'b0, 1'b0);
        repeat (LAT) step(2'b01, 1'b1, 1'b0, 1'b0);
        step(2'b01, 1'b1, 1'b1, 1'b0);
        repeat (6) step(2'b01, 1'b1, 1'b0, 1'b0);

        // Reset with two operations in flight, then a fresh 7*9
        step('0, 1'b0, 1'b0, 1'b0);
        c3 = cyc;
        step(2'b11, 1'b1, 1'b0, 1'b0);
        step(2'b10, 1'b1, 1'b0, 1'b0);
        step('0, 1'b1, 1'b0, 1'b0);
        step('0, 1'b0, 1'b0, 1'b0);
        ra[1] = 256'd7;
        rb[1] = 256'd9;
        c5 = cyc;
        step(2'b10, 1'b1, 1'b0, 1'b0);
        repeat (8) step('0, 1'b1, 1'b0, 1'b0);

        // Randomized traffic with occasional resets
        step('0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 400; i++) begin
            rn = ($urandom_range(0, 99) != 0);
            step(N'($urandom_range(0, (1 << N) - 1)), rn, 1'b0, 1'b0);
        end
        repeat (10) step('0, 1'b1, 1'b0, 1'b0);

        // Hand-computed expectations
        chk("lit_t1_grant", W'(obs_grant[c0]), W'(2'b01));
        chk("lit_t1_issue", W'(obs_mul_valid[c0+1]), W'(1'b1));
        chk("lit_t1_rsp_valid", W'(obs_rsp_valid[c0+6]), W'(2'b01));
        chk("lit_t1_rsp_data", obs_rsp_data[c0+6], 256'd15);
        chk("lit_alt_g0", W'(obs_grant[c1]), W'(2'b01));
        chk("lit_alt_g1", W'(obs_grant[c1+1]), W'(2'b10));
        chk("lit_alt_g2", W'(obs_grant[c1+2]), W'(2'b00));
        chk("lit_alt_g6", W'(obs_grant[c1+6]), W'(2'b01));
        chk("lit_alt_g7", W'(obs_grant[c1+7]), W'(2'b10));
        chk("lit_alt_r6", W'(obs_rsp_valid[c1+6]), W'(2'b01));
        chk("lit_alt_r7", W'(obs_rsp_valid[c1+7]), W'(2'b10));
        chk("lit_inj_err0", W'(obs_err[ci]), W'(1'b0));
        chk("lit_inj_err1", W'(obs_err[ci+1]), W'(1'b1));
        chk("lit_inj_err4", W'(obs_err[ci+4]), W'(1'b1));
        chk("lit_inj_rsp", W'(obs_rsp_valid[ci+1]), W'(2'b00));
        chk("lit_sup_rsp", W'(obs_rsp_valid[c2+6]), W'(2'b00));
        chk("lit_sup_err", W'(obs_err[c2+6]), W'(1'b1));
        chk("lit_sup_grant", W'(obs_grant[c2+9]), W'(2'b00));
        chk("lit_rst_mulv", W'(obs_mul_valid[c3+4]), W'(1'b0));
        chk("lit_rst_err", W'(obs_err[c3+4]), W'(1'b0));
        chk("lit_rst_rsp", W'(obs_rsp_valid[c5+6]), W'(2'b10));
        chk("lit_rst_data", obs_rsp_data[c5+6], 256'd63);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
